sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
Sequences every access to the shared 1M x 16 asynchronous SRAM and shares it among three requesters: the waveform recorder (port 0), the reference matcher (port 1) and the USB readout engine (port 2). It owns the SRAM address bus, data-bus direction and all strobes, so requesters no longer drive OE/WE timing directly. It runs one fixed-timing SRAM cycle at a time, chosen round-robin, with an optional strict priority for the recorder.

Parameters:
AW, 20, SRAM address width
DW, 16, SRAM data width
ACC_CYC, 2, clocks the OE or WE strobe is held low (legal range 1..15)
PRIO0, 1, 1 = port 0 wins whenever it requests; 0 = pure round-robin

Ports:
CLK  in  1  system clock (125 MHz)
RST  in  1  synchronous reset, active-high
EN  in  1  1 = new grants allowed; 0 = finish the current cycle, then hold in IDLE
REQ  in  3  per-port request, level-held until that port's ACK
WE_REQ  in  3  per-port direction: 1 = write, 0 = read
ADDR0/ADDR1/ADDR2  in  AW each  per-port word address
WDATA0/WDATA1/WDATA2  in  DW each  per-port write data
ACK  out  3  one-clock completion pulse, at most one bit set
RDATA  out  DW  read data, valid in the ACK cycle and held until the next read capture
BUSY  out  1  high in any state other than IDLE
ADX  out  AW  SRAM address
DX_O  out  DW  SRAM write data
DX_I  in  DW  SRAM read data
DX_OE  out  1  tri-state enable for DX_O, driven at top level
CEX  out  1  SRAM OE_n
CEY  out  1  SRAM WE_n
CE1  out  1  SRAM CE1_n
CE2  out  1  SRAM CE2
BHE  out  1  byte-high enable_n
BLE  out  1  byte-low enable_n

Behaviour:
- All outputs are registered.
- Reset values: ACK=0, RDATA=0, BUSY=0, ADX=0, DX_O=0, DX_OE=0, CEX=1, CEY=1, CE1=1, CE2=1, BHE=0, BLE=0. Internal state: state=IDLE, last-winner pointer LAST=2.
- FSM states: IDLE -> SETUP (1 clk) -> ACCESS (ACC_CYC clks) -> HOLD (1 clk) -> IDLE.
- Arbitration happens only in IDLE, and only when EN=1 and REQ!=0.
  - If PRIO0=1 and REQ[0]=1, port 0 wins.
  - Otherwise the winner is the first requesting port scanning LAST+1, LAST+2, LAST (mod 3).
  - LAST is set to the winner.
- At the grant edge: ADX, the write flag and the write data are latched from the winner, and the state moves to SETUP.
- REQ, ADDR, WDATA and WE_REQ are ignored outside IDLE. A request dropped mid-cycle still completes and still produces an ACK.
- Strobe levels by state:
  - IDLE: CE1=1, CEX=1, CEY=1, DX_OE=0.
  - SETUP: CE1=0; for a write, DX_OE=1; strobes stay high.
  - ACCESS: read drives CEX=0; write drives CEY=0 with DX_OE=1.
  - HOLD: CEX=1, CEY=1, CE1=0. A write keeps DX_OE=1 (one clock of data hold after WE_n rises); a read has DX_OE=0.
- Read capture: on the final ACCESS clock edge, DX_I is registered into RDATA.
- ACK[winner]=1 for the single HOLD cycle, for both reads and writes.
- Latency: REQ sampled high in IDLE at edge k gives ACK high during cycle k+2+ACC_CYC. The next grant can occur at edge k+3+ACC_CYC, so throughput is one access per ACC_CYC+3 clocks.
- CEX and CEY are never low in the same cycle. DX_OE is never 1 while CEX=0.
- Boundaries:
  - ADX passes any value 0..2^AW-1 unchanged, with no wrap logic; address arithmetic belongs to the requesters.
  - Simultaneous requests are resolved by PRIO0/LAST as above.
  - EN falling mid-cycle does not abort the cycle.
  - RST mid-cycle: the next edge forces reset values, no ACK is issued for the aborted access, and RDATA is cleared.
- The requester must deassert REQ in the cycle after its ACK, or it is re-arbitrated as a new request.

Test Plan:
- Single read: after reset, ACC_CYC=2, REQ=3'b100, WE_REQ=0, ADDR2=0x00005, model returns 0x1234 -> CEX low for exactly 2 clks, ACK=3'b100 at grant+4 clks, RDATA=0x1234, CEY stays 1.
- Single write: port 1 writes 0xBEEF to 0x40000 -> DX_OE high for 1+2+1 clks, CEY low for 2 clks inside that window, ADX=0x40000, model memory reads 0xBEEF afterwards.
- Round-robin: PRIO0=0, REQ=3'b111 held, each port drops REQ for one cycle after its ACK -> grant order 0,1,2,0,1,2, successive ACKs 5 clks apart.
- Priority: PRIO0=1, ports 1 and 2 requesting continuously, port 0 requests every 20 clks -> each port-0 request is granted at the next IDLE (ACK within 10 clks); ports 1 and 2 alternate otherwise.
- EN gating: EN=0 asserted during ACCESS -> the current ACK still occurs, BUSY=0 afterwards, and no grants follow despite REQ=3'b011; raising EN lets a grant occur on the next edge.
- Reset mid-ACCESS of a write: RST=1 for 1 clk -> next cycle CEY=1, DX_OE=0, CE1=1, ACK=0, BUSY=0; assertion checkers confirm the strobe-exclusion rules across all cycles.

Source files
------------

// File: rtl/sram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter_if
// Purpose  : Requester-side bus of the shared SRAM arbiter. Carries the
//            per-port request/direction/address/write-data bundle towards the
//            arbiter and the ACK/RDATA/BUSY status back to the requesters.
// Modports : master - requester side (drives requests, observes status)
//            slave  - arbiter side (observes requests, drives status)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_access_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 16
);
    logic          en;        // 1 = new grants allowed
    logic [2:0]    req;       // per-port request, held until ACK
    logic [2:0]    we_req;    // per-port direction, 1 = write
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic [2:0]    ack;       // one-clock completion pulse
    logic [DW-1:0] rdata;     // read data, held until next read capture
    logic          busy;      // arbiter not in IDLE

    modport master (
        output en, req, we_req, addr0, addr1, addr2, wdata0, wdata1, wdata2,
        input  ack, rdata, busy
    );

    modport slave (
        input  en, req, we_req, addr0, addr1, addr2, wdata0, wdata1, wdata2,
        output ack, rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter
// Purpose  : Owns the asynchronous 1M x 16 SRAM and runs one fixed-timing
//            access at a time (SETUP, ACC_CYC x ACCESS, HOLD) for three
//            requesters, chosen round-robin with optional strict priority
//            for port 0. Every output is registered.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            bus (slave)   - requester bundle: en/req/we_req/addr/wdata in,
//                            ack/rdata/busy out
//            adx_o, dx_o   - SRAM address and write data
//            dx_i          - SRAM read data
//            dx_oe_o       - tri-state enable for dx_o
//            cex_o/cey_o   - OE_n / WE_n
//            ce1_o/ce2_o   - CE1_n / CE2
//            bhe_o/ble_o   - byte enables (active-low, always enabled)
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_arbiter #(
    parameter int AW      = 20,
    parameter int DW      = 16,
    parameter int ACC_CYC = 2,
    parameter int PRIO0   = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sram_access_arbiter_if.slave bus,
    output logic [AW-1:0]      adx_o,
    output logic [DW-1:0]      dx_o,
    input  wire logic [DW-1:0] dx_i,
    output logic               dx_oe_o,
    output logic               cex_o,
    output logic               cey_o,
    output logic               ce1_o,
    output logic               ce2_o,
    output logic               bhe_o,
    output logic               ble_o
);

    localparam logic [3:0] c_acc_last = 4'(ACC_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    win_q, win_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] adx_q, adx_d;
    logic [DW-1:0] dxo_q, dxo_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          oe_q, oe_d;
    logic          cex_q, cex_d;
    logic          cey_q, cey_d;
    logic          ce1_q, ce1_d;

    logic [1:0]    w_pick;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // First requesting port in the order LAST+1, LAST+2, LAST (mod 3).
    // Scanning backwards lets the earliest candidate overwrite the others.
    function automatic logic [1:0] f_rr_pick(input logic [2:0] req,
                                             input logic [1:0] last);
        logic [1:0] cand;
        f_rr_pick = last;
        for (int i = 3; i >= 1; i--) begin
            cand = 2'((int'(last) + i) % 3);
            if (req[cand]) f_rr_pick = cand;
        end
    endfunction

    always_comb begin
        w_pick = ((PRIO0 != 0) && bus.req[0]) ? 2'd0 : f_rr_pick(bus.req, last_q);
        case (w_pick)
            2'd0:    begin w_we = bus.we_req[0]; w_addr = bus.addr0; w_wdata = bus.wdata0; end
            2'd1:    begin w_we = bus.we_req[1]; w_addr = bus.addr1; w_wdata = bus.wdata1; end
            default: begin w_we = bus.we_req[2]; w_addr = bus.addr2; w_wdata = bus.wdata2; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        adx_d   = adx_q;
        dxo_d   = dxo_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.en && (bus.req != 3'b000)) begin
                    state_d = S_SETUP;
                    win_d   = w_pick;
                    last_d  = w_pick;
                    wr_d    = w_we;
                    adx_d   = w_addr;
                    dxo_d   = w_wdata;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = c_acc_last;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                    if (!wr_q) rdata_d = dx_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being
        // entered: the pins then show the levels of the state they are in.
        busy_d = (state_d != S_IDLE);
        ce1_d  = (state_d == S_IDLE);
        cex_d  = !((state_d == S_ACCESS) && !wr_d);
        cey_d  = !((state_d == S_ACCESS) && wr_d);
        oe_d   = wr_d && (state_d != S_IDLE);
        ack_d  = (state_d == S_HOLD) ? (3'b001 << win_d) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 2'd2;
            win_q   <= 2'd0;
            wr_q    <= 1'b0;
            adx_q   <= '0;
            dxo_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            cex_q   <= 1'b1;
            cey_q   <= 1'b1;
            ce1_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            adx_q   <= adx_d;
            dxo_q   <= dxo_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
            cex_q   <= cex_d;
            cey_q   <= cey_d;
            ce1_q   <= ce1_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign adx_o     = adx_q;
    assign dx_o      = dxo_q;
    assign dx_oe_o   = oe_q;
    assign cex_o     = cex_q;
    assign cey_o     = cey_q;
    assign ce1_o     = ce1_q;
    // Chip enable 2 and both byte enables are permanently active.
    assign ce2_o     = 1'b1;
    assign bhe_o     = 1'b0;
    assign ble_o     = 1'b0;

endmodule
`default_nettype wire
